// File: rtl/regfile_pkg.sv
// Shared types and constants for the ID-stage register file and its write-back scoreboard.
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_pend_cnt.sv
// Saturating count of in-flight writes to one register; flags issue-at-max and retire-at-zero.
module regfile_pend_cnt #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              ovf_c_o,
  output logic              unf_c_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] cnt_q, cnt_d;

  // A simultaneous issue and retire swap producers, so the count is unchanged.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_c_o = 1'b0;
    unf_c_o = 1'b0;
    if (inc_i && !dec_i) begin
      if (cnt_q == CNT_MAX) ovf_c_o = 1'b1;
      else                  cnt_d   = cnt_q + PEND_W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) unf_c_o = 1'b1;
      else             cnt_d   = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS ID-stage register file with WB->ID bypass, hardwired zero register and
// per-register pending-write counters that drive operand-busy flags for the hazard unit.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned PEND_W = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     issue_en_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     any_busy_o,
  output logic                     err_ovf_o,
  output logic                     err_unf_o
);

  localparam int unsigned       DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(regfile_pkg::ZERO_REG);

  logic [DATA_W-1:0]            regs_q [DEPTH];
  logic [DEPTH-1:0][PEND_W-1:0] cnt;
  logic [DEPTH-1:0]             ovf_c, unf_c;
  logic                         err_ovf_q, err_unf_q;
  logic                         wr_ok_c;

  assign wr_ok_c = wr_en_i && (wr_addr_i != ZERO_IDX);

  // Register 0 has no producer tracking.
  assign cnt[0]   = '0;
  assign ovf_c[0] = 1'b0;
  assign unf_c[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_pend
    regfile_pend_cnt #(.PEND_W(PEND_W)) u_pend_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (issue_en_i && (issue_addr_i == ADDR_W'(r))),
      .dec_i   (wr_en_i && (wr_addr_i == ADDR_W'(r))),
      .cnt_o   (cnt[r]),
      .ovf_c_o (ovf_c[r]),
      .unf_c_o (unf_c[r])
    );
  end

  // Storage; entry 0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else if (wr_ok_c) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read muxes; a producer retiring this cycle forwards its data and no longer blocks.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    rd_data_o = '0;
    rd_busy_o = '0;
    ra        = '0;
    fwd       = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr_i[i*ADDR_W +: ADDR_W];
      fwd = (BYPASS != 0) && wr_en_i && (wr_addr_i == ra);
      if (ra != ZERO_IDX) begin
        rd_data_o[i*DATA_W +: DATA_W] = fwd ? wr_data_i : regs_q[ra];
        rd_busy_o[i]                  = (cnt[ra] - PEND_W'(fwd)) != '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | (|ovf_c);
      err_unf_q <= err_unf_q | (|unf_c);
    end
  end

  assign any_busy_o = |cnt;
  assign err_ovf_o  = err_ovf_q;
  assign err_unf_o  = err_unf_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a BYPASS=1 and a BYPASS=0 instance share stimulus
// and are checked against an independent register/pending-counter model.
module tb_regfile_scoreboard;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned PW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data, rd_data_nb;
  logic [NR-1:0]    rd_busy, rd_busy_nb;
  logic             issue_en = 1'b0;
  logic [AW-1:0]    issue_addr = '0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             any_busy, err_ovf, err_unf;
  logic             any_busy_nb, err_ovf_nb, err_unf_nb;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .any_busy_o(any_busy), .err_ovf_o(err_ovf), .err_unf_o(err_unf)
  );

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_nb), .rd_busy_o(rd_busy_nb),
    .issue_en_i(issue_en), .issue_addr_i(issue_addr), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .any_busy_o(any_busy_nb), .err_ovf_o(err_ovf_nb), .err_unf_o(err_unf_nb)
  );

  typedef enum int {
    K_RD0, K_RD1, K_BUSY0, K_BUSY1, K_ANY, K_OVF, K_UNF,
    K_NB_RD0, K_NB_BUSY0, K_NB_ANY, K_NB_OVF, K_NB_UNF
  } kind_e;

  typedef struct {
    kind_e       kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [DW-1:0] mregs [32];
  logic [PW-1:0] mpc   [32];
  logic          movf, munf;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_RD0:      return rd_data[DW-1:0];
      K_RD1:      return rd_data[2*DW-1:DW];
      K_BUSY0:    return 32'(rd_busy[0]);
      K_BUSY1:    return 32'(rd_busy[1]);
      K_ANY:      return 32'(any_busy);
      K_OVF:      return 32'(err_ovf);
      K_UNF:      return 32'(err_unf);
      K_NB_RD0:   return rd_data_nb[DW-1:0];
      K_NB_BUSY0: return 32'(rd_busy_nb[0]);
      K_NB_ANY:   return 32'(any_busy_nb);
      K_NB_OVF:   return 32'(err_ovf_nb);
      default:    return 32'(err_unf_nb);
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      mpc[r]   = '0;
    end
    movf = 1'b0;
    munf = 1'b0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return mregs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    logic [PW-1:0] d;
    if (a == 0) return 1'b0;
    d = mpc[a] - PW'((byp && wr_en && wr_addr == a) ? 1 : 0);
    return d != '0;
  endfunction

  function automatic logic exp_any();
    logic b = 1'b0;
    for (int r = 0; r < 32; r++) if (mpc[r] != '0) b = 1'b1;
    return b;
  endfunction

  task automatic push(input kind_e k, input string tag, input logic [31:0] e);
    exp_t x;
    x.kind = k;
    x.tag  = $sformatf("%s.%s", tag, k.name());
    x.exp  = e;
    sb_q.push_back(x);
  endtask

  task automatic push_all(input string tag);
    logic [AW-1:0] a0, a1;
    a0 = rd_addr[AW-1:0];
    a1 = rd_addr[2*AW-1:AW];
    push(K_RD0, tag, exp_rd(a0, 1'b1));
    push(K_RD1, tag, exp_rd(a1, 1'b1));
    push(K_BUSY0, tag, 32'(exp_busy(a0, 1'b1)));
    push(K_BUSY1, tag, 32'(exp_busy(a1, 1'b1)));
    push(K_ANY, tag, 32'(exp_any()));
    push(K_OVF, tag, 32'(movf));
    push(K_UNF, tag, 32'(munf));
    push(K_NB_RD0, tag, exp_rd(a0, 1'b0));
    push(K_NB_BUSY0, tag, 32'(exp_busy(a0, 1'b0)));
    push(K_NB_ANY, tag, 32'(exp_any()));
    push(K_NB_OVF, tag, 32'(movf));
    push(K_NB_UNF, tag, 32'(munf));
  endtask

  task automatic drain();
    exp_t x;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check(x.tag, observe(x.kind), x.exp);
    end
  endtask

  // Apply the effect of the coming rising edge to the model.
  task automatic model_edge();
    bit iss, w;
    if (!rst) return;
    iss = issue_en && issue_addr != 0;
    w   = wr_en && wr_addr != 0;
    if (w) mregs[wr_addr] = wr_data;
    if (!(iss && w && issue_addr == wr_addr)) begin
      if (iss) begin
        if (mpc[issue_addr] == '1) movf = 1'b1;
        else mpc[issue_addr] = mpc[issue_addr] + PW'(1);
      end
      if (w) begin
        if (mpc[wr_addr] == '0) munf = 1'b1;
        else mpc[wr_addr] = mpc[wr_addr] - PW'(1);
      end
    end
  endtask

  task automatic step(input string tag, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                      input bit ie, input logic [AW-1:0] ia,
                      input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    @(negedge clk);
    rd_addr    = {ra1, ra0};
    issue_en   = ie;
    issue_addr = ia;
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    push_all(tag);
    #2;
    drain();
    model_edge();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    push_all("reset");
    drain();
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 16; k++)
      step("t1_zero", AW'(2*k), AW'(2*k+1), 0, 0, 0, 0, 0);
    step("t1_wr9", 9, 0, 0, 0, 1, 9, 32'h1);
    step("t1_rd9", 9, 0, 0, 0, 0, 0, 0);

    step("t2_byp", 8, 9, 0, 0, 1, 8, 32'hDEAD);
    step("t2_after", 8, 9, 0, 0, 0, 0, 0);

    step("t3_iss1", 5, 0, 1, 5, 0, 0, 0);
    step("t3_iss2", 5, 0, 1, 5, 0, 0, 0);
    step("t3_wr1", 5, 0, 0, 0, 1, 5, 32'h55);
    step("t3_mid", 5, 0, 0, 0, 0, 0, 0);
    step("t3_wr2", 5, 0, 0, 0, 1, 5, 32'h56);
    step("t3_done", 5, 0, 0, 0, 0, 0, 0);

    step("t4_iss", 7, 0, 1, 7, 0, 0, 0);
    step("t4_both", 7, 0, 1, 7, 1, 7, 32'h77);
    step("t4_hold", 7, 0, 0, 0, 0, 0, 0);
    step("t4_wr0", 0, 7, 0, 0, 1, 0, 32'hFFFF);
    step("t4_rd0", 0, 7, 0, 0, 0, 0, 0);
    step("t4_drain", 7, 0, 0, 0, 1, 7, 32'h78);

    for (int k = 0; k < 4; k++) step("t5_iss3", 3, 0, 1, 3, 0, 0, 0);
    step("t5_ovf", 3, 0, 0, 0, 0, 0, 0);
    step("t5_wr4", 4, 3, 0, 0, 1, 4, 32'h44);
    step("t5_unf", 4, 3, 0, 0, 0, 0, 0);
    step("t5_sticky", 4, 3, 0, 0, 0, 0, 0);

    step("t6_wr3", 3, 4, 0, 0, 1, 3, 32'h33);
    step("t6_pc2", 3, 4, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    push_all("t6_async");
    drain();
    @(negedge clk);
    rst = 1'b1;
    step("t6_post", 3, 4, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
